uvmt_cv32e40x_obi_mem_responder: RTL and testbench
==================================================

Name: uvmt_cv32e40x_obi_mem_responder

Overview:
- Synthesizable OBI responder (memory slave) for the core's OBI data or instruction initiator port in the uvmt_cv32e40x bench.
- Grants requests, performs byte-enabled writes and reads into an internal word array, and returns rvalid/rdata/err/exokay after a fixed latency.
- Limits outstanding transactions, so the core's pipelined OBI path sees back-pressure.
- Sits between the core wrapper's OBI ports and the bench, as a self-contained alternative to the UVM OBI memory agent.

Parameters:
- ADDR_WIDTH, 32, OBI address width.
- DATA_WIDTH, 32, OBI data width (fixed 32 in this revision).
- MEM_WORDS, 1024, number of 32-bit words; valid byte range is 0 .. 4*MEM_WORDS-1.
- RVALID_LATENCY, 1, cycles from grant to rvalid; legal range 1..8.
- MAX_OUTSTANDING, 2, maximum granted-but-unresponded transactions; legal range 1..8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  OBI address-phase request
- gnt_o  out  1  OBI grant
- addr_i  in  ADDR_WIDTH  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- atop_i  in  6  atomic op; nonzero is unsupported
- rvalid_o  out  1  response valid, one cycle per transaction
- rdata_o  out  32  read data
- err_o  out  1  bus error
- exokay_o  out  1  exclusive okay; always 0
- outstanding_o  out  4  current outstanding count (status/coverage)

Behaviour:
- Reset (rst_i sampled high at a clk_i edge):
  - rvalid_o=0, rdata_o=0, err_o=0, exokay_o=0, outstanding_o=0.
  - Response pipeline flushed; in-flight transactions are dropped with no rvalid.
  - Memory array contents are NOT cleared.
- Grant:
  - gnt_o = req_i & ~rst_i & (outstanding < MAX_OUTSTANDING), combinational.
  - A response popped in the same cycle does not free a slot for that cycle; the slot frees on the next cycle.
  - Accept means req_i & gnt_o at a rising edge. Address-phase signals are sampled only on accept.
- Address decode:
  - word index = addr_i[ADDR_WIDTH-1:2]; addr_i[1:0] is ignored.
  - In range means word index < MEM_WORDS.
- Error conditions:
  - Triggered by out-of-range address or atop_i != 0.
  - Response has err_o=1 and rdata_o=0. No memory write occurs.
- Write:
  - On accept, bytes with be_i[k]=1 take wdata_i[8k+7:8k]; other bytes are unchanged.
  - Response rdata_o=0, err_o=0.
  - be_i=0 is a legal write with no byte modified.
- Read:
  - Memory is sampled at the accept edge, so it reflects every write accepted earlier, including the immediately preceding cycle.
  - be_i does not mask rdata_o; the full word is returned.
- Response pipeline:
  - RVALID_LATENCY-stage shift register of {valid, rdata, err}.
  - Accept at edge N gives rvalid_o=1 during the cycle after edge N+RVALID_LATENCY-1; RVALID_LATENCY=1 means rvalid is visible in the cycle after the grant cycle.
  - Responses are strictly in order. rvalid_o is high for exactly one cycle per accepted transaction.
  - Back-to-back accepts give back-to-back rvalids.
  - rdata_o and err_o hold their last response value when rvalid_o=0.
- Outstanding counter:
  - +1 on accept, -1 on rvalid_o; both in one cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- exokay_o is tied 0; no exclusive support.

Optional Feature:
- Macro: UVMT_CV32E40X_OBI_RESP_STALL_EN.
- With it:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - gnt_o is additionally ANDed with ~lfsr[0], giving pseudo-random grant stalls that repeat identically after every reset.
  - Address-phase signals must be held stable by the initiator while stalled; no assertion is required in this block.
- Without it: no LFSR is present and grant depends only on req_i, rst_i and the outstanding count.

Test Plan:
- Reset value check: hold rst_i=1 for 3 cycles with req_i=1 -> gnt_o=0, rvalid_o=0, outstanding_o=0; after release, gnt_o=1 in the first cycle.
- Byte-enabled write then read, RVALID_LATENCY=1:
  - Stimulus: write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then write addr 0x10, wdata 0x00001122, be 4'h3; then read addr 0x10.
  - Required: read rvalid_o one cycle after its grant with rdata_o=0xDEAD1122, err_o=0.
- Back-pressure, MAX_OUTSTANDING=2, RVALID_LATENCY=4:
  - Stimulus: req_i held high for 6 cycles.
  - Required: gnt_o is high on cycles 0 and 1, low until the first rvalid, and outstanding_o never exceeds 2.
- Error response:
  - Read at addr 4*MEM_WORDS gives err_o=1, rdata_o=0.
  - Write with atop_i=6'h20 to addr 0x0 gives err_o=1, and a following read of 0x0 returns the prior value unchanged.
- Reset mid-operation: assert rst_i while 2 transactions are outstanding -> no rvalid for them, outstanding_o=0; memory written before the reset still reads back correctly.
- Stall feature (macro defined): 64 cycles of req_i=1 -> gnt_o pattern equals ~lfsr[0] from seed 0xA5, identical across two resets.

Source files
------------

// File: rtl/uvmt_cv32e40x_obi_mem_responder.sv
// OBI memory responder: grants requests, performs byte-enabled reads and
// writes on an internal word array, and answers in order after a fixed latency.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_i / gnt_o        address-phase handshake (gnt_o is combinational)
//   addr_i, we_i, be_i,  address-phase payload, sampled only on accept
//   wdata_i, atop_i      (a nonzero atop_i is answered with an error)
//   rvalid_o, rdata_o,   response phase, one rvalid_o pulse per transaction;
//   err_o, exokay_o      rdata_o/err_o hold between responses, exokay_o is 0
//   outstanding_o        granted-but-unanswered transaction count
//
// Optional build macro UVMT_CV32E40X_OBI_RESP_STALL_EN adds LFSR-driven
// pseudo-random grant stalls (8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5).
module uvmt_cv32e40x_obi_mem_responder #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned RVALID_LATENCY  = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [5:0]            atop_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  exokay_o,
    output logic [3:0]            outstanding_o
);

    localparam int unsigned IW = ADDR_WIDTH - 2;
    localparam int unsigned MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned L  = RVALID_LATENCY;
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [IW-1:0] widx_full;
    logic [MW-1:0] widx;
    logic [1:0]    unused_addr;
    logic          in_range;
    logic          stall;
    logic          accept;
    logic          wr_en;
    logic          rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic [3:0] cnt_q, cnt_d;
    logic [L-1:0] vld_q, vld_d;
    logic [L-1:0] err_q, err_d;
    logic [L-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

    assign widx_full   = addr_i[ADDR_WIDTH-1:2];
    assign widx        = widx_full[MW-1:0];
    assign unused_addr = addr_i[1:0];
    assign in_range    = widx_full < IW'(MEM_WORDS);

`ifdef UVMT_CV32E40X_OBI_RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Uses the registered count, so a response leaving this cycle only
    // frees its slot from the next cycle on.
    assign gnt_o  = req_i & ~rst_i & (cnt_q < MAX_OUT) & ~stall;
    assign accept = req_i & gnt_o;

    assign rsp_err  = ~in_range | (|atop_i);
    assign wr_en    = accept & we_i & ~rsp_err;
    assign rsp_data = (rsp_err | we_i) ? '0 : mem_q[widx];

    // Memory is deliberately left untouched by reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) mem_q[widx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // Data/err only move along with a valid entry, so the last stage
    // keeps the previous response while no new one arrives.
    always_comb begin
        vld_d    = '0;
        err_d    = err_q;
        dat_d    = dat_q;
        vld_d[0] = accept;
        if (accept) begin
            dat_d[0] = rsp_data;
            err_d[0] = rsp_err;
        end
        for (int i = 1; i < L; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
                err_d[i] = err_q[i-1];
            end
        end
    end

    always_comb begin
        case ({accept, rvalid_o})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    assign rvalid_o      = vld_q[L-1];
    assign rdata_o       = dat_q[L-1];
    assign err_o         = err_q[L-1];
    assign exokay_o      = 1'b0;
    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_mem_responder.sv
// Bench for uvmt_cv32e40x_obi_mem_responder: scoreboard on a latency-1
// instance plus directed back-pressure and reset checks on a latency-4 one.
module tb_uvmt_cv32e40x_obi_mem_responder;

    localparam int MW   = 1024;
    localparam int L    = 1;
    localparam int MAXO = 2;

`ifdef UVMT_CV32E40X_OBI_RESP_STALL_EN
    localparam logic EXP_FIRST_G = 1'b0;
`else
    localparam logic EXP_FIRST_G = 1'b1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, gnt, we, rvalid, err, exokay;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be, outst;
    logic [5:0]  atop;

    logic        b_rst, b_req, b_gnt, b_we, b_rvalid, b_err, b_exokay;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be, b_outst;
    logic [5:0]  b_atop;

    uvmt_cv32e40x_obi_mem_responder #(
        .MEM_WORDS(MW), .RVALID_LATENCY(L), .MAX_OUTSTANDING(MAXO)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .atop_i(atop), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .exokay_o(exokay), .outstanding_o(outst)
    );

    uvmt_cv32e40x_obi_mem_responder #(
        .MEM_WORDS(MW), .RVALID_LATENCY(4), .MAX_OUTSTANDING(2)
    ) u_bp (
        .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .gnt_o(b_gnt),
        .addr_i(b_addr), .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata),
        .atop_i(b_atop), .rvalid_o(b_rvalid), .rdata_o(b_rdata),
        .err_o(b_err), .exokay_o(b_exokay), .outstanding_o(b_outst)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [int];

    // Reference LFSR (used only by the stall-feature checks).
    logic [7:0] lm;
    always @(posedge clk) begin
        if (rst) lm <= 8'hA5;
        else     lm <= {lm[6:0], lm[7] ^ lm[5] ^ lm[4] ^ lm[3]};
    end

    task automatic push(input logic [31:0] d, input logic e);
        exp_t x;
        x.d   = d;
        x.e   = e;
        x.due = cyc + L;
        sb.push_back(x);
    endtask

    // Reference behaviour for one accepted transaction.
    task automatic model(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd,
                         input logic [5:0] at);
        int          idx;
        logic [31:0] old;
        idx = int'(a >> 2);
        if (idx >= MW || at != 6'd0) begin
            push(32'h0, 1'b1);
        end else if (w) begin
            old = mem_m.exists(idx) ? mem_m[idx] : 32'hx;
            for (int k = 0; k < 4; k++)
                if (b[k]) old[8*k +: 8] = wd[8*k +: 8];
            mem_m[idx] = old;
            push(32'h0, 1'b0);
        end else begin
            push(mem_m[idx], 1'b0);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd,
                        input logic [5:0] at, output logic first_g);
        req = 1'b1; we = w; addr = a; be = b; wdata = wd; atop = at;
        first_g = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) first_g = gnt;
            if (gnt) begin
                model(w, a, b, wd, at);
                @(posedge clk); #1;
                req = 1'b0;
                return;
            end
        end
        chk("gnt_timeout", 32'd0, 32'd1);
        req = 1'b0;
    endtask

    bit          mon_en = 1'b0;
    logic [31:0] last_d;
    logic        last_e;

    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            chk("outst_max", {31'b0, outst > 4'(MAXO)}, 32'd0);
            if (rvalid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("err", {31'b0, err}, {31'b0, e.e});
                    chk("rvalid_cycle", cyc, e.due);
                    chk("exokay", {31'b0, exokay}, 32'd0);
                end
                last_d = rdata;
                last_e = err;
            end else begin
                chk("rdata_hold", rdata, last_d);
                chk("err_hold", {31'b0, err}, {31'b0, last_e});
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic b_xfer(input logic w, input logic [31:0] a,
                          input logic [31:0] wd);
        b_req = 1'b1; b_we = w; b_addr = a; b_be = 4'hF;
        b_wdata = wd; b_atop = 6'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_gnt) begin
                @(posedge clk); #1;
                b_req = 1'b0;
                return;
            end
        end
        chk("b_gnt_timeout", 32'd0, 32'd1);
        b_req = 1'b0;
    endtask

    task automatic b_wait_rvalid(output logic [31:0] d, output logic e);
        d = 32'h0;
        e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_rvalid) begin
                d = b_rdata;
                e = b_err;
                return;
            end
        end
        chk("b_rvalid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic        g;
        logic [31:0] a, d, r;
        logic [3:0]  bm;
        logic        e;
        logic [5:0]  bp_gnt, bp_rv;
        int          bp_out[6];
        logic [63:0] pat0, pat1;

        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'h0;
        wdata = 32'hFFFF_FFFF; atop = 6'd0;
        b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0;
        b_be = 4'h0; b_wdata = 32'h0; b_atop = 6'd0;
        pat0 = '0; pat1 = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", {31'b0, gnt}, 32'd0);
            chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
            chk("rst_outst", {28'b0, outst}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; b_rst = 1'b0;
        last_d = 32'h0; last_e = 1'b0;
        mon_en = 1'b1;

        // be=0 write while req is already high from reset.
        xfer(1'b1, 32'h0, 4'h0, 32'hFFFF_FFFF, 6'd0, g);
        chk("first_gnt", {31'b0, g}, {31'b0, EXP_FIRST_G});

        xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 6'd0, g);
        xfer(1'b1, 32'h10, 4'h3, 32'h0000_1122, 6'd0, g);
        xfer(1'b0, 32'h10, 4'hF, 32'h0, 6'd0, g);

        xfer(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 6'd0, g);
        xfer(1'b1, 32'h0, 4'hF, 32'h1234_5678, 6'h20, g);
        xfer(1'b0, 32'h0, 4'hF, 32'h0, 6'd0, g);

        xfer(1'b0, 32'(4 * MW), 4'hF, 32'h0, 6'd0, g);
        xfer(1'b1, 32'(4 * MW - 4), 4'hF, 32'h0BAD_CAFE, 6'd0, g);
        xfer(1'b0, 32'(4 * MW - 4), 4'hF, 32'h0, 6'd0, g);
        xfer(1'b1, 32'(4 * MW + 8), 4'hF, 32'h5555_5555, 6'd0, g);
        xfer(1'b0, 32'h10, 4'h0, 32'h0, 6'd0, g);
        xfer(1'b0, 32'h13, 4'h1, 32'h0, 6'd0, g);

        for (int i = 0; i < 8; i++) begin
            a  = {20'h0, 10'($urandom_range(0, MW - 1)), 2'b00};
            d  = $urandom;
            r  = $urandom;
            bm = 4'($urandom_range(0, 15));
            xfer(1'b1, a, 4'hF, d, 6'd0, g);
            xfer(1'b1, a, bm, r, 6'd0, g);
            xfer(1'b0, a, 4'h0, 32'h0, 6'd0, g);
        end
        drain();

`ifdef UVMT_CV32E40X_OBI_RESP_STALL_EN
        for (int run = 0; run < 2; run++) begin
            mon_en = 1'b0;
            rst = 1'b1; req = 1'b1; we = 1'b1; be = 4'h0;
            addr = 32'h0; atop = 6'd0;
            @(posedge clk); #1;
            rst = 1'b0;
            last_d = 32'h0; last_e = 1'b0;
            mon_en = 1'b1;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                chk("stall_gnt", {31'b0, gnt}, {31'b0, ~lm[0]});
                if (run == 0) pat0[k] = gnt;
                else          pat1[k] = gnt;
                if (gnt) push(32'h0, 1'b0);
            end
            @(posedge clk); #1;
            req = 1'b0;
            drain();
        end
        chk("stall_repeat_lo", pat0[31:0], pat1[31:0]);
        chk("stall_repeat_hi", pat0[63:32], pat1[63:32]);
`else
        // Back-pressure on the latency-4 instance, cycle by cycle.
        bp_gnt = 6'b100011;
        bp_rv  = 6'b110000;
        bp_out = '{0, 1, 2, 2, 2, 1};
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b1; b_be = 4'h0; b_addr = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("bp_gnt%0d", k), {31'b0, b_gnt}, {31'b0, bp_gnt[k]});
            chk($sformatf("bp_rv%0d", k), {31'b0, b_rvalid}, {31'b0, bp_rv[k]});
            chk($sformatf("bp_out%0d", k), {28'b0, b_outst}, 32'(bp_out[k]));
        end
        @(posedge clk); #1;
        b_req = 1'b0;
        for (int i = 0; i < 20 && (b_outst != 0 || b_rvalid); i++)
            @(negedge clk);
        chk("bp_drain", {28'b0, b_outst}, 32'd0);
`endif

        // Reset with transactions in flight on the latency-4 instance.
        b_xfer(1'b1, 32'h20, 32'hA5A5_5A5A);
        b_wait_rvalid(d, e);
        chk("b_wr_err", {31'b0, e}, 32'd0);
        b_xfer(1'b0, 32'h20, 32'h0);
        b_xfer(1'b0, 32'h20, 32'h0);
`ifndef UVMT_CV32E40X_OBI_RESP_STALL_EN
        @(negedge clk);
        chk("b_outst_pre", {28'b0, b_outst}, 32'd2);
`endif
        @(posedge clk); #1;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b_flush_rvalid", {31'b0, b_rvalid}, 32'd0);
        end
        chk("b_flush_outst", {28'b0, b_outst}, 32'd0);
        chk("b_flush_rdata", b_rdata, 32'd0);
        b_xfer(1'b0, 32'h20, 32'h0);
        b_wait_rvalid(d, e);
        chk("b_keep_rdata", d, 32'hA5A5_5A5A);
        chk("b_keep_err", {31'b0, e}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
